// File: rtl/peripheral_axi4_master_burst_engine.sv
// Single-outstanding AXI4 master: one command becomes one INCR burst, with write
// data streamed in, read data streamed out, and a done pulse carrying the worst response.
module peripheral_axi4_master_burst_engine #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int ID      = 0,
  parameter int MAX_LEN = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            err,
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SZ     = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, REJECT} state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [ADDR_W-1:0]   cmd_addr_al;
  logic [15:0]         burst_end;
  logic                illegal;
  logic                in_w, in_r, last_beat;
  logic [1:0]          r_err;

  // Byte offset one past the final beat within the 4 KB page; 16 bits covers 256 x 32 B.
  assign cmd_addr_al = cmd_addr & ~ADDR_W'(STRB_W - 1);
  assign burst_end   = {4'd0, cmd_addr_al[11:0]} + ({8'd0, cmd_len} + 16'd1) * 16'(STRB_W);
  assign illegal     = (int'(cmd_len) >= MAX_LEN) || (burst_end > 16'd4096);

  assign in_w      = (state == WDATA);
  assign in_r      = (state == RDATA);
  assign last_beat = (cnt == 8'd0);

  assign wvalid   = in_w & wr_valid;
  assign wr_ready = in_w & wready;
  assign wdata    = wr_data;
  assign wstrb    = wr_strb;
  assign wlast    = in_w & last_beat;

  assign rd_valid = in_r & rvalid;
  assign rready   = in_r & rd_ready;
  assign rd_data  = rdata;
  assign rd_last  = in_r & last_beat;

  assign awid    = ID_W'(ID);
  assign arid    = ID_W'(ID);
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = len_q;
  assign arlen   = len_q;
  assign awsize  = 3'(SZ);
  assign arsize  = 3'(SZ);
  assign awburst = 2'b01;
  assign arburst = 2'b01;

  // A slave rlast that disagrees with our own beat count is reported as SLVERR.
  always_comb begin
    r_err = (rresp > err) ? rresp : err;
    if (rlast != last_beat) r_err = 2'b10;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      awvalid   <= 1'b0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      done      <= 1'b0;
      err       <= 2'b00;
      addr_q    <= '0;
      len_q     <= 8'd0;
      cnt       <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr_al;
            len_q     <= cmd_len;
            cnt       <= cmd_len;
            err       <= 2'b00;
            if (illegal) begin
              state <= REJECT;
              done  <= 1'b1;
              err   <= 2'b10;
            end else if (cmd_write) begin
              state   <= WADDR;
              awvalid <= 1'b1;
            end else begin
              state   <= RADDR;
              arvalid <= 1'b1;
            end
          end
        end
        REJECT: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        WADDR: if (awready) begin
          awvalid <= 1'b0;
          state   <= WDATA;
        end
        WDATA: if (wr_valid && wready) begin
          if (last_beat) begin
            state  <= WRESP;
            bready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WRESP: if (bvalid) begin
          bready <= 1'b0;
          err    <= bresp;
          done   <= 1'b1;
          state  <= IDLE;
        end
        RADDR: if (arready) begin
          arvalid <= 1'b0;
          state   <= RDATA;
        end
        RDATA: if (rvalid && rd_ready) begin
          err <= r_err;
          if (last_beat) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
